sa_host_link: RTL and testbench

//  Host-side transmitter/receiver for systolic_array's byte-serial port. It collects 16 A bytes and 16 B bytes in row-major order.
//  It pulses the array's reset, raises en and streams the 32 bytes into p_shift_in in the array's load order.
//  It then waits for ack, captures the 16 C bytes from p_shift_out and returns them to the host as a stream.
//  It sits between the host bus glue and the systolic_array top, and lets tests and firmware drive jobs without hand-sequencing.

---
 rtl/sa_pkg.sv | 28 ++
 rtl/sa_host_buf.sv | 21 ++
 rtl/sa_host_link.sv | 171 +++++++++++++++++
 tb/tb_sa_host_link.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared sizes, FSM state encoding and the array load-order mapping for sa_host_link.
package sa_pkg;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NN = N * N;
  localparam int AW = $clog2(2 * NN);

  typedef enum logic [3:0] {
    IDLE, FILL, ARST, PRE, SHIFT, WAIT, CAP, DRAIN, ERR
  } state_e;

  // Buffer address of the k-th byte the array expects: A rows reversed, then B columns reversed.
  function automatic logic [AW-1:0] load_idx(input logic [AW-1:0] k);
    int unsigned kk, m, i, j;
    kk = 32'(k);
    if (kk < NN) begin
      i = kk / N;
      j = kk % N;
      return AW'(i * N + (N - 1 - j));
    end
    m = kk - NN;
    i = m / N;
    j = m % N;
    return AW'(NN + (N - 1 - j) * N + i);
  endfunction

endpackage

// File: rtl/sa_host_buf.sv
// A/B staging register file: one synchronous write port, one asynchronous read port.
module sa_host_buf
  import sa_pkg::*;
(
  input  logic          clk_p,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2*NN];

  always_ff @(posedge clk_p) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sa_host_link.sv
// Host-side front end for systolic_array: buffers A/B, sequences reset and the
// byte-serial load, then captures C on ack and returns it as a ready/valid stream.
module sa_host_link
  import sa_pkg::*;
#(
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 256
) (
  input  logic          clk_p,
  input  logic          rst_p,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          err,
  output logic          sa_rstn,
  output logic          sa_en,
  output logic [DW-1:0] sa_shift_in,
  input  logic [DW-1:0] sa_shift_out,
  input  logic          sa_ack
);

  localparam int CW = $clog2(NN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_K = AW'(2 * NN - 1);
  localparam logic [AW-1:0] LAST_R = AW'(RST_CYC - 1);
  localparam logic [CW-1:0] LAST_C = CW'(NN - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, raddr;
  logic [CW-1:0] cnt_q, cnt_d, rptr_q, rptr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] res_q [NN];
  logic [DW-1:0] buf_rdata, rd_data_q, sa_shift_in_q;
  logic          wr_fire, rd_fire, buf_we, cap;
  logic          wr_ready_q, rd_valid_q, busy_q, err_q, sa_rstn_q, sa_en_q;

  assign wr_fire = wr_valid & wr_ready_q;
  assign rd_fire = rd_valid_q & rd_ready;
  assign raddr   = load_idx(ptr_d);

  sa_host_buf u_buf (
    .clk_p   (clk_p),
    .we_i    (buf_we),
    .waddr_i (ptr_q),
    .wdata_i (wr_data),
    .raddr_i (raddr),
    .rdata_o (buf_rdata)
  );

  // ptr_q is shared: fill address, reset-hold count, then shift index k.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    tmo_d   = tmo_q;
    buf_we  = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: if (wr_fire) begin
        buf_we  = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        state_d = FILL;
      end
      FILL: if (wr_fire) begin
        buf_we = 1'b1;
        if (ptr_q == LAST_K) begin
          ptr_d   = '0;
          state_d = ARST;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ARST: if (ptr_q == LAST_R) begin
        ptr_d   = '0;
        state_d = PRE;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
      PRE: state_d = SHIFT;
      SHIFT: if (ptr_q == LAST_K) begin
        ptr_d   = '0;
        state_d = WAIT;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
      WAIT: if (sa_ack) begin
        cap     = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        tmo_d   = '0;
        state_d = CAP;
      end else if (tmo_q == LAST_T) begin
        tmo_d   = '0;
        state_d = ERR;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      CAP: if (sa_ack) begin
        cap = 1'b1;
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: if (rd_fire) begin
        if (rptr_q == LAST_C) begin
          rptr_d  = '0;
          state_d = IDLE;
        end else begin
          rptr_d = rptr_q + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      rptr_q        <= '0;
      tmo_q         <= '0;
      wr_ready_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      sa_rstn_q     <= 1'b0;
      sa_en_q       <= 1'b0;
      rd_data_q     <= '0;
      sa_shift_in_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      rptr_q        <= rptr_d;
      tmo_q         <= tmo_d;
      wr_ready_q    <= (state_d == IDLE) || (state_d == FILL);
      rd_valid_q    <= (state_d == DRAIN);
      busy_q        <= !((state_d == IDLE) || (state_d == ERR));
      err_q         <= err_q | (state_d == ERR);
      sa_rstn_q     <= (state_d != ARST);
      sa_en_q       <= (state_d == PRE) || ((state_d == SHIFT) && (ptr_d != LAST_K));
      sa_shift_in_q <= (state_d == SHIFT) ? buf_rdata : '0;
      if (state_d == DRAIN) rd_data_q <= res_q[rptr_d];
    end
  end

  always_ff @(posedge clk_p) begin
    if (cap) res_q[cnt_q] <= sa_shift_out;
  end

  assign wr_ready    = wr_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign sa_rstn     = sa_rstn_q;
  assign sa_en       = sa_en_q;
  assign sa_shift_in = sa_shift_in_q;

endmodule

// File: tb/tb_sa_host_link.sv
// Directed bench for sa_host_link with a behavioural systolic_array stub that
// decodes the load stream, multiplies A*B and returns C on ack.
`timescale 1ns/1ps
module tb_sa_host_link;

  localparam int RST_CYC = 2;
  localparam int TIMEOUT = 256;
  localparam int T       = 10;

  logic       clk_p = 1'b0;
  logic       rst_p = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'd0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       busy, err, sa_rstn, sa_en;
  logic [7:0] sa_shift_in;
  logic [7:0] sa_shift_out = 8'hA5;
  logic       sa_ack = 1'b0;

  always #(T/2) clk_p = ~clk_p;

  sa_host_link #(.RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk_p(clk_p), .rst_p(rst_p),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .err(err), .sa_rstn(sa_rstn), .sa_en(sa_en),
    .sa_shift_in(sa_shift_in), .sa_shift_out(sa_shift_out), .sa_ack(sa_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- array stub ----------------
  logic [7:0] job [32];
  logic [7:0] sh_log [32];
  logic       en_log [32];
  logic [7:0] c_arr [16];
  logic [7:0] got [16];
  logic [7:0] exp_cur [16];
  int  st = 0, nb = 0, oi = 0, lat = 0;
  bit  no_ack = 0, gap_en = 0, hit10 = 0;
  time t_lastwr, t_b0, t_b31, t_lastack, t_first_rv;

  always @(negedge clk_p) begin
    if (!sa_rstn) begin
      st = 0; nb = 0; sa_ack = 1'b0; sa_shift_out = 8'hA5;
    end else begin
      case (st)
        0: if (sa_en) st = 1;
        1: begin
          if (nb == 0) t_b0 = $time;
          sh_log[nb] = sa_shift_in;
          en_log[nb] = sa_en;
          nb++;
          if (nb == 11) hit10 = 1;
          if (nb == 32) begin
            for (int i = 0; i < 4; i++)
              for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                // A[i][x] arrives at k=4i+3-x; B[x][j] arrives at 16+4j+3-x
                for (int x = 0; x < 4; x++)
                  s += int'(sh_log[4*i + 3 - x]) * int'(sh_log[16 + 4*j + 3 - x]);
                c_arr[4*i + j] = 8'(s);
              end
            t_b31 = $time;
            st = 2; oi = 0; lat = 2;
          end
        end
        2: begin
          if (no_ack) sa_ack = 1'b0;
          else if (lat > 0) begin lat--; sa_ack = 1'b0; end
          else if (oi == 16) begin sa_ack = 1'b0; sa_shift_out = 8'hA5; st = 3; end
          else if (gap_en && $urandom_range(0, 2) == 0) begin sa_ack = 1'b0; sa_shift_out = 8'hA5; end
          else begin
            sa_ack = 1'b1;
            sa_shift_out = c_arr[oi];
            oi++;
            if (oi == 16) t_lastack = $time;
          end
        end
        default: sa_ack = 1'b0;
      endcase
    end
  end

  // ---------------- host tasks ----------------
  task automatic set_job(input int sel);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        case (sel)
          1: begin job[4*i+j] = 8'(j + 1); job[16+4*i+j] = 8'(i + 1); end
          2: begin
            job[4*i+j]    = (i == 0 || i == 3 || j == 0 || j == 3) ? 8'd1 : 8'd0;
            job[16+4*i+j] = 8'(2 * (4*i + j) + 12);
          end
          3: begin
            job[4*i+j]    = 8'(3 * (4*i + j));
            job[16+4*i+j] = (i == j) ? 8'd2 : ((i + j == 3) ? 8'd1 : 8'd0);
          end
          default: begin
            job[4*i+j]    = 8'(200 + 4*i + j);
            job[16+4*i+j] = (i == j) ? 8'd2 : 8'd0;
          end
        endcase
      end
  endtask

  task automatic send_job();
    for (int i = 0; i < 32; i++) begin
      int w;
      w = 0;
      @(negedge clk_p);
      wr_valid = 1'b1;
      wr_data  = job[i];
      while (!wr_ready && w < 50) begin @(negedge clk_p); w++; end
      if (!wr_ready) begin
        chk("wr_ready_wait", 32'(wr_ready), 32'd1);
        wr_valid = 1'b0;
        return;
      end
      @(posedge clk_p);
      t_lastwr = $time;
    end
    @(negedge clk_p);
    wr_valid = 1'b0;
  endtask

  task automatic read_res(input bit rnd);
    int  w, n;
    bit  hold, seen;
    logic [7:0] prev;
    w = 0; n = 0; hold = 0; seen = 0; prev = 8'd0;
    while (n < 16 && w < 3000) begin
      @(negedge clk_p);
      w++;
      if (hold) begin
        chk("rd_hold_valid", 32'(rd_valid), 32'd1);
        chk("rd_hold_data", 32'(rd_data), 32'(prev));
      end
      if (rd_valid && !seen) begin seen = 1; t_first_rv = $time; end
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = 0;
      if (rd_valid && rd_ready) begin got[n] = rd_data; n++; end
      else if (rd_valid) begin hold = 1; prev = rd_data; end
    end
    chk("rd_count", 32'(n), 32'd16);
    chk("ack_to_rd_valid", 32'(t_first_rv - t_lastack), 32'(T));
    @(negedge clk_p);
    rd_ready = 1'b0;
    chk("rd_valid_after", 32'(rd_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_c%0d", tag, i), 32'(got[i]), 32'(exp_cur[i]));
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  localparam logic [7:0] EXP2 [16] = '{96,104,112,120, 48,52,56,60, 48,52,56,60, 96,104,112,120};
  localparam logic [7:0] EXP3 [16] = '{9,12,15,18, 45,48,51,54, 81,84,87,90, 117,120,123,126};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    time t_err;
    // reset state
    repeat (3) @(posedge clk_p);
    @(negedge clk_p);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sa_rstn", 32'(sa_rstn), 32'd0);
    chk("rst_sa_en", 32'(sa_en), 32'd0);
    chk("rst_sa_shift_in", 32'(sa_shift_in), 32'd0);
    rst_p = 1'b0;
    @(negedge clk_p);
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);
    chk("idle_sa_rstn", 32'(sa_rstn), 32'd1);

    // job 1: every C element is 1+4+9+16 = 30; load order is 4,3,2,1 repeated
    set_job(1);
    send_job();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_wr_ready_low", 32'(wr_ready), 32'd0);
    read_res(0);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t1_shift%0d", k), 32'(sh_log[k]), 32'(4 - (k % 4)));
      chk($sformatf("t1_en%0d", k), 32'(en_log[k]), (k < 31) ? 32'd1 : 32'd0);
    end
    // write cycle to first-byte cycle spans RST_CYC+2 cycles; byte sampled mid-cycle
    chk("t1_load_latency", 32'(t_b0 - t_lastwr), 32'((RST_CYC + 1) * T + T / 2));
    for (int i = 0; i < 16; i++) exp_cur[i] = 8'd30;
    check_results("t1");

    set_job(2);
    send_job();
    read_res(0);
    exp_cur = EXP2;
    check_results("t2");

    set_job(3);
    send_job();
    read_res(0);
    exp_cur = EXP3;
    check_results("t3");

    // job 6: ack gaps, random backpressure; 2*(200+idx) wraps to 144+2*idx
    gap_en = 1;
    set_job(6);
    send_job();
    read_res(1);
    for (int i = 0; i < 16; i++) exp_cur[i] = 8'(144 + 2 * i);
    check_results("t6");
    gap_en = 0;

    // job 4: no ack -> timeout error
    no_ack = 1;
    set_job(1);
    send_job();
    w = 0;
    t_err = 0;
    while (!err && w < TIMEOUT + 100) begin @(negedge clk_p); w++; end
    chk("t4_err_set", 32'(err), 32'd1);
    t_err = $time;
    chk("t4_err_latency", 32'(t_err - t_b31), 32'((TIMEOUT + 1) * T));
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_wr_ready", 32'(wr_ready), 32'd0);
    chk("t4_sa_en", 32'(sa_en), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 8'd7;
    repeat (5) @(negedge clk_p);
    chk("t4_wr_ready_held", 32'(wr_ready), 32'd0);
    chk("t4_err_sticky", 32'(err), 32'd1);
    wr_valid = 1'b0;
    rst_p = 1'b1;
    @(negedge clk_p);
    chk("t4_err_cleared", 32'(err), 32'd0);
    rst_p = 1'b0;
    no_ack = 0;
    @(negedge clk_p);

    // job 5: reset during shift byte 10, then a clean job
    hit10 = 0;
    set_job(3);
    fork
      send_job();
    join_none
    w = 0;
    while (!hit10 && w < 500) begin @(negedge clk_p); #1; w++; end
    chk("t5_reached_byte10", 32'(hit10), 32'd1);
    rst_p = 1'b1;
    @(negedge clk_p);
    chk("t5_sa_en", 32'(sa_en), 32'd0);
    chk("t5_sa_rstn", 32'(sa_rstn), 32'd0);
    chk("t5_wr_ready", 32'(wr_ready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rd_valid", 32'(rd_valid), 32'd0);
    rst_p = 1'b0;
    @(negedge clk_p);
    chk("t5_idle_wr_ready", 32'(wr_ready), 32'd1);
    set_job(2);
    send_job();
    read_res(0);
    exp_cur = EXP2;
    check_results("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
